// File: rtl/qenc_pkg.sv
// qenc_pkg: direction encodings, Gray phase type and quadrature step helpers
package qenc_pkg;
  typedef enum logic [1:0] {DIR_IDLE = 2'b00, DIR_CW = 2'b01, DIR_CCW = 2'b10} dir_t;
  typedef enum logic [1:0] {PH_00 = 2'b00, PH_01 = 2'b01, PH_11 = 2'b11, PH_10 = 2'b10} phase_t;
  function automatic phase_t cw_next(input phase_t p);
    return phase_t'({p[0], ~p[1]});
  endfunction
  function automatic phase_t ccw_next(input phase_t p);
    return phase_t'({~p[0], p[1]});
  endfunction
endpackage

// File: rtl/qenc_channel.sv
// qenc_channel: one encoder channel (sync, filter, decode, position, direction, error).
// Step-period measurement is built only when QENC_VELOCITY_EN is defined.
module qenc_channel
  import qenc_pkg::*;
#(
  parameter int POS_W       = 32,
  parameter int FILT_LEN    = 4,
  parameter int IDLE_CYCLES = 5_000_000,
  parameter int PER_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_raw,
  input  logic             b_raw,
  input  logic             clear,
  output logic [1:0]       dir,
  output logic [POS_W-1:0] position,
  output logic             error,
  output logic [PER_W-1:0] period
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic [1:0] s1, s2, smp, lvl;
  logic [1:0][FW-1:0] cnt;
  phase_t cur, last;
  logic cw, ccw, bad, idle_hit;
  logic [IW-1:0] idle;
  // smp is the filter's own sampling stage, so acceptance lands 3+FILT_LEN edges after capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      smp  <= '0;
      lvl  <= '0;
      cnt  <= '0;
      last <= PH_00;
    end else begin
      s1   <= {a_raw, b_raw};
      s2   <= s1;
      smp  <= s2;
      last <= cur;
      for (int k = 0; k < 2; k++)
        if (smp[k] == lvl[k]) cnt[k] <= '0;
        else if (cnt[k] == FW'(FILT_LEN - 1)) begin
          lvl[k] <= smp[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
    end
  always_comb begin
    cur      = phase_t'(lvl);
    cw       = cur == cw_next(last);
    ccw      = cur == ccw_next(last);
    bad      = (cur ^ last) == 2'b11;
    idle_hit = idle == IW'(IDLE_CYCLES);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      position <= '0;
      error    <= 1'b0;
      dir      <= DIR_IDLE;
      idle     <= '0;
    end else begin
      position <= clear ? '0 : cw ? position + 1'b1 : ccw ? position - 1'b1 : position;
      error    <= !clear && (error || bad);
      idle     <= (cw || ccw) ? '0 : idle_hit ? idle : idle + 1'b1;
      dir      <= cw ? DIR_CW : ccw ? DIR_CCW : idle_hit ? DIR_IDLE : dir;
    end
`ifdef QENC_VELOCITY_EN
  logic [PER_W-1:0] pcnt;
  // a saturated count means "unknown/too slow", reported as all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pcnt   <= '1;
      period <= '1;
    end else if (cw || ccw) begin
      period <= &pcnt ? pcnt : pcnt + 1'b1;
      pcnt   <= '0;
    end else if (idle_hit) begin
      period <= '1;
      pcnt   <= '1;
    end else if (!(&pcnt)) pcnt <= pcnt + 1'b1;
`else
  assign period = '1;
`endif
endmodule

// File: rtl/quad_encoder_array.sv
// quad_encoder_array: NUM_CH independent quadrature decoders; wiring only.
// Define QENC_VELOCITY_EN to enable per-channel step-period measurement.
module quad_encoder_array
  import qenc_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int POS_W       = 32,
  parameter int FILT_LEN    = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int IDLE_CYCLES = CLK_FREQ / 10,
  parameter int PER_W       = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ENCA_raw,
  input  logic [NUM_CH-1:0]       ENCB_raw,
  input  logic [NUM_CH-1:0]       clear,
  output logic [2*NUM_CH-1:0]     DIR,
  output logic [POS_W*NUM_CH-1:0] position,
  output logic [NUM_CH-1:0]       error,
  output logic [PER_W*NUM_CH-1:0] period
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    qenc_channel #(
      .POS_W(POS_W), .FILT_LEN(FILT_LEN), .IDLE_CYCLES(IDLE_CYCLES), .PER_W(PER_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .a_raw   (ENCA_raw[i]),
      .b_raw   (ENCB_raw[i]),
      .clear   (clear[i]),
      .dir     (DIR[2*i +: 2]),
      .position(position[i*POS_W +: POS_W]),
      .error   (error[i]),
      .period  (period[i*PER_W +: PER_W])
    );
  end
endmodule

// File: tb/tb_quad_encoder_array.sv
// tb_quad_encoder_array: directed table-driven checks plus hand-written corner sequences.
// Cycle counts are scaled down (idle 5000, step gap 500); a 4-bit instance covers wrap-around.
module tb_quad_encoder_array;
  localparam int IDLE = 5000;
  localparam int GAP  = 500;
`ifdef QENC_VELOCITY_EN
  localparam logic [23:0] PER_EXP = 24'd500;
`else
  localparam logic [23:0] PER_EXP = 24'hFFFFFF;
`endif
  logic clk = 0, reset = 1;
  logic [1:0] a_raw = '0, b_raw = '0, clr = '0;
  logic [3:0] dir;
  logic [31:0] pos;
  logic [1:0] err;
  logic [47:0] per;
  logic [0:0] wa = '0, wb = '0, wclr = '0;
  logic [1:0] wdir;
  logic [3:0] wpos;
  logic [0:0] werr;
  logic [23:0] wper;
  int n_cmp = 0, n_bad = 0;

  quad_encoder_array #(.NUM_CH(2), .POS_W(16), .FILT_LEN(4), .IDLE_CYCLES(IDLE), .PER_W(24)) dut (
    .clk(clk), .reset(reset), .ENCA_raw(a_raw), .ENCB_raw(b_raw), .clear(clr),
    .DIR(dir), .position(pos), .error(err), .period(per));

  quad_encoder_array #(.NUM_CH(1), .POS_W(4), .FILT_LEN(4), .IDLE_CYCLES(IDLE), .PER_W(24)) dut_w (
    .clk(clk), .reset(reset), .ENCA_raw(wa), .ENCB_raw(wb), .clear(wclr),
    .DIR(wdir), .position(wpos), .error(werr), .period(wper));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] ab; logic [15:0] p; logic [1:0] d;} vec_t;
  vec_t tbl[25];
  logic [1:0] cw_seq[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set0(input logic [1:0] ab);
    a_raw[0] = ab[1];
    b_raw[0] = ab[0];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tbl = '{'{2'b01, 16'd1, 2'b01}, '{2'b11, 16'd2, 2'b01}, '{2'b10, 16'd3, 2'b01},
            '{2'b00, 16'd4, 2'b01}, '{2'b01, 16'd5, 2'b01}, '{2'b11, 16'd6, 2'b01},
            '{2'b10, 16'd7, 2'b01}, '{2'b00, 16'd8, 2'b01}, '{2'b01, 16'd9, 2'b01},
            '{2'b11, 16'd10, 2'b01},
            '{2'b01, 16'd9, 2'b10}, '{2'b00, 16'd8, 2'b10}, '{2'b10, 16'd7, 2'b10},
            '{2'b11, 16'd6, 2'b10}, '{2'b01, 16'd5, 2'b10}, '{2'b00, 16'd4, 2'b10},
            '{2'b10, 16'd3, 2'b10}, '{2'b11, 16'd2, 2'b10}, '{2'b01, 16'd1, 2'b10},
            '{2'b00, 16'd0, 2'b10}, '{2'b10, 16'hFFFF, 2'b10}, '{2'b11, 16'hFFFE, 2'b10},
            '{2'b01, 16'hFFFD, 2'b10}, '{2'b00, 16'hFFFC, 2'b10}, '{2'b10, 16'hFFFB, 2'b10}};
    cw_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    wait_cyc(3);
    chk("rst_pos", pos, 32'h0);
    chk("rst_dir", {28'h0, dir}, 32'h0);
    chk("rst_err", {30'h0, err}, 32'h0);
    chk("rst_per0", {8'h0, per[23:0]}, 32'hFFFFFF);
    chk("rst_per1", {8'h0, per[47:24]}, 32'hFFFFFF);
    reset = 0;
    wait_cyc(2);
    for (int i = 0; i < 25; i++) begin
      set0(tbl[i].ab);
      wait_cyc(GAP);
      chk($sformatf("vec%0d_pos0", i), {16'h0, pos[15:0]}, {16'h0, tbl[i].p});
      chk($sformatf("vec%0d_dir0", i), {30'h0, dir[1:0]}, {30'h0, tbl[i].d});
      chk($sformatf("vec%0d_err0", i), {31'h0, err[0]}, 32'h0);
      if (i == 9 || i == 24) begin
        chk($sformatf("vec%0d_per0", i), {8'h0, per[23:0]}, {8'h0, PER_EXP});
        chk($sformatf("vec%0d_pos1", i), {16'h0, pos[31:16]}, 32'h0);
        chk($sformatf("vec%0d_dir1", i), {30'h0, dir[3:2]}, 32'h0);
      end
    end
    wait_cyc(IDLE + 1000);
    chk("idle_dir0", {30'h0, dir[1:0]}, 32'h0);
    chk("idle_per0", {8'h0, per[23:0]}, 32'hFFFFFF);
    chk("idle_pos0", {16'h0, pos[15:0]}, 32'hFFFB);
    // latency: update must land on the 7th rising edge counting the first sampling edge as edge 0
    set0(2'b00);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 chk("lat_early_pos0", {16'h0, pos[15:0]}, 32'hFFFB);
    @(posedge clk);
    #1 chk("lat_pos0", {16'h0, pos[15:0]}, 32'hFFFC);
    chk("lat_dir0", {30'h0, dir[1:0]}, 32'h1);
    wait_cyc(20);
    set0(2'b10);
    wait_cyc(2);
    set0(2'b00);
    wait_cyc(30);
    chk("glitch_pos0", {16'h0, pos[15:0]}, 32'hFFFC);
    chk("glitch_dir0", {30'h0, dir[1:0]}, 32'h1);
    chk("glitch_err0", {31'h0, err[0]}, 32'h0);
    a_raw[1] = 1;
    b_raw[1] = 1;
    wait_cyc(30);
    chk("illegal_pos1", {16'h0, pos[31:16]}, 32'h0);
    chk("illegal_err1", {31'h0, err[1]}, 32'h1);
    chk("illegal_dir1", {30'h0, dir[3:2]}, 32'h0);
    chk("indep_err0", {31'h0, err[0]}, 32'h0);
    chk("indep_pos0", {16'h0, pos[15:0]}, 32'hFFFC);
    b_raw[1] = 0;
    wait_cyc(30);
    chk("sticky_pos1", {16'h0, pos[31:16]}, 32'h1);
    chk("sticky_err1", {31'h0, err[1]}, 32'h1);
    clr[1] = 1;
    wait_cyc(1);
    clr[1] = 0;
    chk("clear_err1", {31'h0, err[1]}, 32'h0);
    chk("clear_pos1", {16'h0, pos[31:16]}, 32'h0);
    chk("clear_dir1", {30'h0, dir[3:2]}, 32'h1);
    chk("clear_pos0", {16'h0, pos[15:0]}, 32'hFFFC);
    for (int k = 0; k < 8; k++) begin
      {wa[0], wb[0]} = cw_seq[k % 4];
      wait_cyc(20);
      if (k == 6) chk("wrap_max", {28'h0, wpos}, 32'h7);
    end
    chk("wrap_max_plus1", {28'h0, wpos}, 32'h8);
    {wa[0], wb[0]} = 2'b10;
    wait_cyc(20);
    chk("wrap_min_minus1", {28'h0, wpos}, 32'h7);
    chk("wrap_dir", {30'h0, wdir}, 32'h2);
    set0(2'b01);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1 chk("midrst_pos", pos, 32'h0);
    chk("midrst_dir", {28'h0, dir}, 32'h0);
    chk("midrst_err", {30'h0, err}, 32'h0);
    chk("midrst_per0", {8'h0, per[23:0]}, 32'hFFFFFF);
    chk("midrst_wpos", {28'h0, wpos}, 32'h0);
    a_raw = '0;
    b_raw = '0;
    wait_cyc(3);
    reset = 0;
    wait_cyc(30);
    chk("postrst_pos", pos, 32'h0);
    chk("postrst_dir", {28'h0, dir}, 32'h0);
    chk("postrst_err", {30'h0, err}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
